// File: rtl/pb_debounce_pulser.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM and Moore-decoded
// single/multi/continuous enables derived from the FSM state and its counter.
module pb_debounce_pulser #(
  parameter int N_dc = 25
) (
  input  logic CLK,
  input  logic RESET,
  input  logic PB,
  output logic DPB,
  output logic SCEN,
  output logic MCEN,
  output logic CCEN
);

  typedef enum logic [2:0] {
    INI     = 3'd0,
    WQ      = 3'd1,
    SCEN_ST = 3'd2,
    WS      = 3'd3,
    MCEN_ST = 3'd4,
    CCR     = 3'd5,
    WFCR    = 3'd6
  } state_t;

  localparam logic [N_dc-1:0] C_ONE   = {{(N_dc-1){1'b0}}, 1'b1};
  localparam logic [N_dc-1:0] C_Q_END = {2'b00, {(N_dc-2){1'b1}}};
  localparam logic [N_dc-1:0] C_S_END = {1'b0, {(N_dc-1){1'b1}}};

  logic            r_s1;
  logic            r_pb_s;
  state_t          r_state;
  logic [N_dc-1:0] r_count;

  state_t          w_nxt_state;
  logic [N_dc-1:0] w_nxt_count;
  logic [N_dc-1:0] w_inc;
  logic [3:0]      w_nxt_out;

  // Output bits are {DPB, SCEN, MCEN, CCEN}, a pure function of state and count.
  function automatic logic [3:0] decode(input state_t st, input logic [N_dc-1:0] cnt);
    logic [3:0] o;
    o = 4'b0000;
    case (st)
      SCEN_ST: o = 4'b1111;
      WS:      o = 4'b1000;
      MCEN_ST: o = 4'b1011;
      CCR:     o = {1'b1, 1'b0, &cnt[N_dc-2:0], &cnt[N_dc-5:0]};
      WFCR:    o = 4'b1000;
      default: o = 4'b0000;
    endcase
    return o;
  endfunction

  assign w_inc = r_count + C_ONE;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_count = '0;
    case (r_state)
      INI: begin
        if (r_pb_s) w_nxt_state = WQ;
      end
      WQ: begin
        if (!r_pb_s)                  w_nxt_state = INI;
        else if (r_count == C_Q_END)  w_nxt_state = SCEN_ST;
        else                          w_nxt_count = w_inc;
      end
      SCEN_ST: w_nxt_state = WS;
      WS: begin
        if (!r_pb_s)                  w_nxt_state = WFCR;
        else if (r_count == C_S_END)  w_nxt_state = MCEN_ST;
        else                          w_nxt_count = w_inc;
      end
      MCEN_ST: w_nxt_state = CCR;
      CCR: begin
        // Free-running wrap here only sets the repeat cadence.
        if (!r_pb_s) w_nxt_state = WFCR;
        else         w_nxt_count = w_inc;
      end
      WFCR: begin
        if (r_pb_s)                   w_nxt_count = '0;
        else if (r_count == C_Q_END)  w_nxt_state = INI;
        else                          w_nxt_count = w_inc;
      end
      default: w_nxt_state = INI;
    endcase
  end

  assign w_nxt_out = decode(w_nxt_state, w_nxt_count);

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_s1    <= 1'b0;
      r_pb_s  <= 1'b0;
      r_state <= INI;
      r_count <= '0;
      DPB     <= 1'b0;
      SCEN    <= 1'b0;
      MCEN    <= 1'b0;
      CCEN    <= 1'b0;
    end else begin
      r_s1    <= PB;
      r_pb_s  <= r_s1;
      r_state <= w_nxt_state;
      r_count <= w_nxt_count;
      {DPB, SCEN, MCEN, CCEN} <= w_nxt_out;
    end
  end

endmodule

// File: tb/tb_pb_debounce_pulser.sv
// Bench for pb_debounce_pulser: a press/release timing model checked every cycle,
// plus directed scenarios with hand-computed edge counts and pulse totals.
module tb_pb_debounce_pulser;

  localparam int N       = 6;
  localparam int QUARTER = 1 << (N - 2);
  localparam int SPAN    = 1 << (N - 1);
  localparam int CCP     = 1 << (N - 4);
  localparam int MCP     = 1 << (N - 1);

  logic CLK = 1'b0;
  logic RESET;
  logic PB;
  logic DPB, SCEN, MCEN, CCEN;

  pb_debounce_pulser #(.N_dc(N)) dut (
    .CLK(CLK), .RESET(RESET), .PB(PB),
    .DPB(DPB), .SCEN(SCEN), .MCEN(MCEN), .CCEN(CCEN)
  );

  always #5 CLK = ~CLK;

  // Model: idle counts a run of high samples; held tracks time since the press
  // was accepted; release needs QUARTER quiet lows after the last disturbance.
  typedef struct packed {
    logic held;
    logic rel;
    int   run;
    int   t;
    int   quiet;
  } mst_t;

  mst_t m;
  logic ms1, ms2;
  logic e_dpb, e_scen, e_mcen, e_ccen;

  function automatic mst_t nxt(input mst_t c, input logic pbs);
    mst_t n;
    n = c;
    if (c.held) begin
      if (!pbs && c.t != 0 && c.t != SPAN + 1) begin
        n.held = 1'b0; n.rel = 1'b1; n.quiet = 0;
      end else n.t = c.t + 1;
    end else if (c.rel) begin
      if (pbs) n.quiet = 0;
      else if (c.quiet + 1 == QUARTER) begin n.rel = 1'b0; n.run = 0; end
      else n.quiet = c.quiet + 1;
    end else begin
      if (!pbs) n.run = 0;
      else if (c.run + 1 == QUARTER + 1) begin n.held = 1'b1; n.t = 0; n.run = 0; end
      else n.run = c.run + 1;
    end
    return n;
  endfunction

  function automatic logic [3:0] outs(input mst_t c);
    logic [3:0] o;
    int k;
    o = {c.held | c.rel, 3'b000};
    if (c.held) begin
      if (c.t == 0) o[2:0] = 3'b111;
      else if (c.t == SPAN + 1) o[1:0] = 2'b11;
      else if (c.t >= SPAN + 2) begin
        k = c.t - (SPAN + 2);
        o[1] = (k % MCP) == MCP - 1;
        o[0] = (k % CCP) == CCP - 1;
      end
    end
    return o;
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m   <= '0;
      ms1 <= 1'b0;
      ms2 <= 1'b0;
      {e_dpb, e_scen, e_mcen, e_ccen} <= 4'b0000;
    end else begin
      ms1 <= PB;
      ms2 <= ms1;
      m   <= nxt(m, ms2);
      {e_dpb, e_scen, e_mcen, e_ccen} <= outs(nxt(m, ms2));
    end
  end

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int n_scen = 0, n_mcen = 0, n_ccen = 0, n_dpb = 0, n_dpb0 = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always begin
    @(negedge CLK);
    #1;
    if (chk_en) begin
      check("model_dpb",  int'(DPB),  int'(e_dpb));
      check("model_scen", int'(SCEN), int'(e_scen));
      check("model_mcen", int'(MCEN), int'(e_mcen));
      check("model_ccen", int'(CCEN), int'(e_ccen));
      n_scen += int'(SCEN === 1'b1);
      n_mcen += int'(MCEN === 1'b1);
      n_ccen += int'(CCEN === 1'b1);
      n_dpb  += int'(DPB === 1'b1);
      n_dpb0 += int'(DPB !== 1'b1);
    end
  end

  // Edges (from the next rising edge) until SCEN (sel=0) or DPB (sel=1) equals level; -1 if never.
  task automatic edges_until(input int sel, input logic level, output int k);
    logic s;
    k = -1;
    for (int i = 1; i <= 80; i++) begin
      @(posedge CLK);
      #2;
      s = (sel == 0) ? SCEN : DPB;
      if (s === level) begin k = i; break; end
    end
  endtask

  int k;
  int b_scen, b_mcen, b_ccen, b_dpb, b_dpb0;

  task automatic snap();
    b_scen = n_scen; b_mcen = n_mcen; b_ccen = n_ccen; b_dpb = n_dpb; b_dpb0 = n_dpb0;
  endtask

  initial begin
    RESET = 1'b0;
    PB    = 1'b1;
    repeat (2) @(posedge CLK);
    chk_en = 1'b1;

    // Reset held with PB high: nothing may come out.
    @(negedge CLK);
    snap();
    repeat (10) @(negedge CLK);
    check("rst_quiet", (n_scen - b_scen) + (n_mcen - b_mcen) + (n_ccen - b_ccen) + (n_dpb - b_dpb), 0);
    RESET = 1'b1;
    edges_until(0, 1'b1, k);
    check("rst_release_to_scen", k, QUARTER + 3);
    @(negedge CLK);
    PB = 1'b0;
    repeat (60) @(negedge CLK);
    check("rst_back_idle", int'(DPB), 0);

    // Clean tap: 40 cycles high.
    snap();
    PB = 1'b1;
    edges_until(0, 1'b1, k);
    check("tap_scen_edge", k, 19);
    check("tap_mcen_with_scen", int'(MCEN), 1);
    check("tap_ccen_with_scen", int'(CCEN), 1);
    check("tap_dpb_with_scen", int'(DPB), 1);
    repeat (21) @(negedge CLK);
    PB = 1'b0;
    edges_until(1, 1'b0, k);
    check("tap_dpb_fall_edge", k, 19);
    repeat (20) @(negedge CLK);
    check("tap_scen_count", n_scen - b_scen, 1);
    check("tap_mcen_count", n_mcen - b_mcen, 1);
    check("tap_ccen_count", n_ccen - b_ccen, 1);

    // Bounce: 5-cycle toggles never reach the quarter time.
    snap();
    for (int i = 0; i < 20; i++) begin
      PB = (i % 2 == 0);
      repeat (5) @(negedge CLK);
    end
    PB = 1'b0;
    repeat (30) @(negedge CLK);
    check("bounce_scen_count", n_scen - b_scen, 0);
    check("bounce_dpb_high_cycles", n_dpb - b_dpb, 0);

    // Long hold: 200 cycles high.
    snap();
    PB = 1'b1;
    repeat (200) @(negedge CLK);
    PB = 1'b0;
    edges_until(1, 1'b0, k);
    check("hold_dpb_fall_edge", k, 19);
    repeat (10) @(negedge CLK);
    check("hold_scen_count", n_scen - b_scen, 1);
    check("hold_mcen_count", n_mcen - b_mcen, 6);
    check("hold_ccen_count", n_ccen - b_ccen, 39);

    // Release bounce: low/high every 8 cycles after a clean press.
    snap();
    PB = 1'b1;
    edges_until(0, 1'b1, k);
    check("relb_scen_edge", k, 19);
    repeat (10) @(negedge CLK);
    snap();
    for (int i = 0; i < 8; i++) begin
      PB = (i % 2 == 1);
      repeat (8) @(negedge CLK);
    end
    check("relb_dpb_low_cycles", n_dpb0 - b_dpb0, 0);
    PB = 1'b0;
    edges_until(1, 1'b0, k);
    check("relb_dpb_fall_edge", k, QUARTER + 2);
    repeat (10) @(negedge CLK);
    check("relb_extra_scen", n_scen - b_scen, 0);

    // Reset while repeating in the hold phase.
    PB = 1'b1;
    edges_until(0, 1'b1, k);
    check("midrst_scen_edge", k, 19);
    repeat (50) @(negedge CLK);
    check("midrst_dpb_before", int'(DPB), 1);
    RESET = 1'b0;
    #1;
    check("midrst_outputs_async", int'({DPB, SCEN, MCEN, CCEN}), 0);
    repeat (5) @(negedge CLK);
    RESET = 1'b1;
    edges_until(0, 1'b1, k);
    check("midrst_fresh_scen_edge", k, 19);
    @(negedge CLK);
    PB = 1'b0;
    repeat (40) @(negedge CLK);
    check("midrst_final_idle", int'(DPB), 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
